// File: rtl/fb_pkg.sv
// fb_pkg: definitions shared by the framebuffer writer and the VGA output stage.
//   - Framebuffer geometry: H_ACTIVE x V_ACTIVE stored pixels per bank.
//   - ADDR_W is the per-bank address width; a full address is {bank, index}.
//   - PIX_W and the RGB444 pixel type with named 4-bit fields.
//   - Writer state encoding.
package fb_pkg;

  localparam int H_ACTIVE = 320;
  localparam int V_ACTIVE = 240;
  localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W   = 17;
  localparam int PIX_W    = 12;
  localparam int ERR_W    = 8;

  // Pixel layout {R[3:0], G[3:0], B[3:0]}.
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam logic [1:0] IDLE_ENC      = 2'd0;
  localparam logic [1:0] WRITE_ENC     = 2'd1;
  localparam logic [1:0] WAIT_SWAP_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = IDLE_ENC,
    WRITE     = WRITE_ENC,
    WAIT_SWAP = WAIT_SWAP_ENC
  } fb_state_t;

endpackage

// File: rtl/fb_frame_checker.sv
// fb_frame_checker: tracks the x/y position of the incoming pixel stream and
// validates the sof/eol markers against the frame geometry.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   state          current writer state (IDLE / WRITE / WAIT_SWAP)
//   accept         a pixel is transferred this cycle
//   sof, eol       markers of the accepted pixel
//   write_ok       accepted pixel is to be written
//   start          written pixel is the first of a frame (index 0)
//   sof_err        sof arrived in the middle of a frame (frame restarts)
//   abort          eol mismatch: pixel dropped, frame abandoned
//   last           written pixel completes the frame
module fb_frame_checker #(
  parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
  parameter int V_ACTIVE = fb_pkg::V_ACTIVE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  fb_pkg::fb_state_t state,
  input  logic              accept,
  input  logic              sof,
  input  logic              eol,
  output logic              write_ok,
  output logic              start,
  output logic              sof_err,
  output logic              abort,
  output logic              last
);
  import fb_pkg::*;

  localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  logic [X_W-1:0] x_reg, x_next;
  logic [Y_W-1:0] y_reg, y_next;
  logic           x_at_end, y_at_end;

  assign x_at_end = (x_reg == X_W'(H_ACTIVE - 1));
  assign y_at_end = (y_reg == Y_W'(V_ACTIVE - 1));

  always_comb begin
    write_ok = 1'b0;
    start    = 1'b0;
    sof_err  = 1'b0;
    abort    = 1'b0;
    last     = 1'b0;
    x_next   = x_reg;
    y_next   = y_reg;
    if (accept) begin
      case (state)
        IDLE: begin
          // Outside a frame only a sof pixel is meaningful.
          if (sof) begin
            write_ok = 1'b1;
            start    = 1'b1;
            x_next   = X_W'(1);
            y_next   = '0;
          end
        end
        WRITE: begin
          if (sof) begin
            // Restart wins over any eol inconsistency on the same pixel.
            write_ok = 1'b1;
            start    = 1'b1;
            sof_err  = 1'b1;
            x_next   = X_W'(1);
            y_next   = '0;
          end else if (eol && x_at_end) begin
            write_ok = 1'b1;
            x_next   = '0;
            if (y_at_end) begin
              last   = 1'b1;
              y_next = '0;
            end else begin
              y_next = y_reg + Y_W'(1);
            end
          end else if (eol || x_at_end) begin
            // Early eol, or eol missing on the last column.
            abort  = 1'b1;
            x_next = '0;
            y_next = '0;
          end else begin
            write_ok = 1'b1;
            x_next   = x_reg + X_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      x_reg <= x_next;
      y_reg <= y_next;
    end
  end

endmodule

// File: rtl/fb_stream_writer.sv
// fb_stream_writer: writes a framed RGB444 pixel stream into one bank of a
// double-buffered BRAM framebuffer and hands finished frames to the VGA
// reader at vertical blank, so the displayed bank never tears.
// Ports:
//   clk, rst_n               pixel clock, asynchronous active-low reset
//   s_valid/s_ready/s_data   pixel stream handshake, s_sof/s_eol markers
//   vblank_pulse             start of vertical blank from the VGA stage
//   wr_en/wr_addr/wr_data    BRAM port A, wr_addr = {bank, pixel index}
//   rd_bank                  bank the VGA reader displays
//   frame_done               pulses with the write of a frame's last pixel
//   err_count                saturating count of framing errors
module fb_stream_writer #(
  parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
  parameter int V_ACTIVE = fb_pkg::V_ACTIVE,
  parameter int PIX_W    = fb_pkg::PIX_W,
  parameter int ADDR_W   = fb_pkg::ADDR_W,
  parameter int ERR_W    = fb_pkg::ERR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_sof,
  input  logic              s_eol,
  input  logic              vblank_pulse,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              rd_bank,
  output logic              frame_done,
  output logic [ERR_W-1:0]  err_count
);
  import fb_pkg::*;

  fb_state_t          state_reg;
  logic               wr_bank_reg;
  logic               rd_bank_reg;
  logic [ADDR_W-1:0]  pix_idx_reg;
  logic               wr_en_reg;
  logic [ADDR_W:0]    wr_addr_reg;
  logic [PIX_W-1:0]   wr_data_reg;
  logic               frame_done_reg;
  logic [ERR_W-1:0]   err_count_reg;

  logic               accept;
  logic               write_ok, start, sof_err, abort, last;
  logic [ADDR_W-1:0]  idx_sel;

  assign s_ready = (state_reg != WAIT_SWAP);
  assign accept  = s_valid & s_ready;

  fb_frame_checker #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (state_reg),
    .accept   (accept),
    .sof      (s_sof),
    .eol      (s_eol),
    .write_ok (write_ok),
    .start    (start),
    .sof_err  (sof_err),
    .abort    (abort),
    .last     (last)
  );

  // The first pixel of a frame always lands at index 0.
  assign idx_sel = start ? '0 : pix_idx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      wr_bank_reg    <= 1'b0;
      rd_bank_reg    <= 1'b1;
      pix_idx_reg    <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      frame_done_reg <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      wr_en_reg      <= write_ok;
      frame_done_reg <= last;

      if (write_ok) begin
        wr_addr_reg <= {wr_bank_reg, idx_sel};
        wr_data_reg <= s_data;
        pix_idx_reg <= idx_sel + ADDR_W'(1);
      end else if (abort) begin
        pix_idx_reg <= '0;
      end

      if ((abort || sof_err) && (err_count_reg != {ERR_W{1'b1}}))
        err_count_reg <= err_count_reg + ERR_W'(1);

      case (state_reg)
        IDLE: begin
          if (start) state_reg <= WRITE;
        end
        WRITE: begin
          if (abort)     state_reg <= IDLE;
          else if (last) state_reg <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          // Only a pulse seen while already waiting swaps the banks.
          if (vblank_pulse) begin
            rd_bank_reg <= wr_bank_reg;
            wr_bank_reg <= ~wr_bank_reg;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign rd_bank    = rd_bank_reg;
  assign frame_done = frame_done_reg;
  assign err_count  = err_count_reg;

endmodule

// File: tb/tb_fb_stream_writer.sv
module tb_fb_stream_writer;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int PW = 12;
  localparam int AW = 17;
  localparam int EW = 8;
  localparam int NPIX = H * V;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [PW-1:0] s_data;
  logic          s_sof;
  logic          s_eol;
  logic          vblank_pulse;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [PW-1:0] wr_data;
  logic          rd_bank;
  logic          frame_done;
  logic [EW-1:0] err_count;

  fb_stream_writer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .PIX_W    (PW),
    .ADDR_W   (AW),
    .ERR_W    (EW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_sof        (s_sof),
    .s_eol        (s_eol),
    .vblank_pulse (vblank_pulse),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_bank      (rd_bank),
    .frame_done   (frame_done),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  bit gaps_en  = 1'b0;

  // Reference model: 0 = outside a frame, 1 = receiving, 2 = frame complete.
  int m_mode, m_pos, m_wbank, m_rbank, m_err;
  bit exp_we, exp_fd;
  int exp_addr, exp_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_wbank = 0; m_rbank = 1; m_err = 0;
    exp_we = 0; exp_fd = 0; exp_addr = 0; exp_data = 0;
  endtask

  task automatic model_err();
    if (m_err < (1 << EW) - 1) m_err++;
  endtask

  task automatic model_emit(input int idx, input int d);
    exp_we   = 1;
    exp_addr = (m_wbank << AW) | idx;
    exp_data = d;
  endtask

  // One clock of the reference behaviour; column = position mod line length.
  task automatic model_cycle(input bit acc, input int d, input bit sof, input bit eol, input bit vb);
    exp_we = 0;
    exp_fd = 0;
    if (m_mode == 2) begin
      if (vb) begin
        m_rbank = m_wbank;
        m_wbank = 1 - m_wbank;
        m_mode  = 0;
      end
    end else if (acc) begin
      if (sof) begin
        if (m_mode == 1) model_err();
        model_emit(0, d);
        m_pos  = 1;
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (eol != ((m_pos % H) == H - 1)) begin
          model_err();
          m_mode = 0;
        end else begin
          model_emit(m_pos, d);
          m_pos++;
          if (m_pos == NPIX) begin
            exp_fd = 1;
            m_mode = 2;
          end
        end
      end
    end
  endtask

  // Called at a falling edge: apply inputs, advance one clock, check outputs.
  task automatic drive_cycle(input bit v, input int d, input bit sof, input bit eol, input bit vb);
    bit acc;
    chk("s_ready", {31'd0, s_ready}, {31'd0, m_mode != 2});
    acc          = v && (m_mode != 2);
    s_valid      = v;
    s_data       = d[PW-1:0];
    s_sof        = sof;
    s_eol        = eol;
    vblank_pulse = vb;
    model_cycle(acc, d, sof, eol, vb);
    @(negedge clk);
    chk("wr_en", {31'd0, wr_en}, {31'd0, exp_we});
    if (exp_we) begin
      chk("wr_addr", 32'(wr_addr), exp_addr);
      chk("wr_data", 32'(wr_data), exp_data);
    end
    chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    chk("err_count", 32'(err_count), m_err);
    chk("rd_bank", {31'd0, rd_bank}, m_rbank);
  endtask

  task automatic idle_cycle(input bit vb);
    drive_cycle(0, $urandom_range(0, 4095), $urandom_range(0, 1), $urandom_range(0, 1), vb);
  endtask

  task automatic send_px(input int d, input bit sof, input bit eol, input bit vb);
    if (gaps_en) begin
      for (int g = 0; g < 3; g++)
        if ($urandom_range(0, 3) == 0) idle_cycle($urandom_range(0, 7) == 0);
    end
    drive_cycle(1, d, sof, eol, vb);
  endtask

  task automatic send_frame(input bit rand_data, input bit vb_on_last, input int start_pos);
    for (int p = start_pos; p < NPIX; p++)
      send_px(rand_data ? int'($urandom_range(0, 4095)) : p + 1,
              p == 0, (p % H) == H - 1, vb_on_last && (p == NPIX - 1));
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 0; s_data = 0; s_sof = 0; s_eol = 0; vblank_pulse = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst wr_en", {31'd0, wr_en}, 0);
    chk("rst wr_addr", 32'(wr_addr), 0);
    chk("rst wr_data", 32'(wr_data), 0);
    chk("rst rd_bank", {31'd0, rd_bank}, 1);
    chk("rst err_count", 32'(err_count), 0);
    chk("rst frame_done", {31'd0, frame_done}, 0);
    rst_n = 1'b1;

    // Clean frame into bank 0, swap, next frame into bank 1.
    send_frame(0, 0, 0);
    idle_cycle(0);
    idle_cycle(1);
    chk("swap rd_bank", {31'd0, rd_bank}, 0);
    send_frame(0, 0, 0);
    idle_cycle(1);

    // Pixels before sof are discarded.
    for (int i = 0; i < 3; i++) drive_cycle(1, 16'h100 + i, 0, i == 2, 0);
    send_frame(1, 0, 0);
    chk("pre-sof err_count", 32'(err_count), 0);
    idle_cycle(1);

    // Early eol on the third pixel.
    send_px(12'h011, 1, 0, 0);
    send_px(12'h012, 0, 0, 0);
    send_px(12'h013, 0, 1, 0);
    chk("early-eol err_count", 32'(err_count), 1);
    send_frame(1, 0, 0);
    idle_cycle(0);
    idle_cycle(1);

    // Mid-frame sof restarts at index 0 and the frame continues from index 1.
    for (int p = 0; p < 5; p++) send_px(12'h020 + p, p == 0, (p % H) == H - 1, 0);
    send_px(12'hABC, 1, 0, 0);
    chk("mid-sof err_count", 32'(err_count), 2);
    send_frame(1, 0, 1);
    idle_cycle(1);

    // Backpressure while waiting for vblank, then vblank on the last accept.
    send_frame(1, 0, 0);
    for (int i = 0; i < 20; i++) drive_cycle(1, 12'hFFF, 0, 0, 0);
    idle_cycle(1);
    send_frame(1, 1, 0);
    for (int i = 0; i < 3; i++) idle_cycle(0);
    idle_cycle(1);

    // Asynchronous reset between edges with a write in flight.
    send_px(12'h031, 1, 0, 0);
    send_px(12'h032, 0, 0, 0);
    send_px(12'h033, 0, 0, 0);
    s_valid = 0;
    rst_n   = 1'b0;
    #1;
    chk("async wr_en", {31'd0, wr_en}, 0);
    chk("async err_count", 32'(err_count), 0);
    chk("async rd_bank", {31'd0, rd_bank}, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive_cycle(1, 12'h040 + i, 0, i == 2, 0);
    send_frame(1, 0, 0);
    idle_cycle(1);

    // Randomized frames with gaps, stray vblanks and occasional marker faults.
    gaps_en = 1'b1;
    for (int f = 0; f < 60; f++) begin
      bit corrupt = ($urandom_range(0, 2) == 0);
      for (int p = 0; p < NPIX; p++) begin
        bit sof = (p == 0);
        bit eol = (p % H) == H - 1;
        if (corrupt && $urandom_range(0, 5) == 0) begin
          if ($urandom_range(0, 1) == 0) eol = !eol;
          else sof = 1'b1;
        end
        send_px($urandom_range(0, 4095), sof, eol, $urandom_range(0, 15) == 0);
      end
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) idle_cycle(0);
      idle_cycle(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
